// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM stream reader: FSM state encoding,
// read-latency bounds and the length clamp.
package bram_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_NEXT    = 3'd4
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_depth);
    return (len > max_depth) ? max_depth : len;
  endfunction

endpackage

// File: rtl/bram_stream_reader_lat_pipe.sv
// Delays the BRAM enable pulse by RD_LAT cycles; the output strobe marks the
// cycle in which bram_dout holds the word addressed by that enable.
module bram_lat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic strobe
);

  logic [RD_LAT-1:0] stage_reg;
  logic [RD_LAT-1:0] stage_next;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = en;
      end else begin : g_tail
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  // clr drops any enable still in flight so an aborted read cannot strobe later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else if (clr) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign strobe = stage_reg[RD_LAT-1];

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a base/length window of a synchronous-read BRAM and hands each word to
// the UART transmitter over a valid/tx_done handshake; one-shot or looping.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int MAX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              loop_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("bram_stream_reader: RD_LAT out of range");
    end
    if (MAX_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("bram_stream_reader: MAX_DEPTH exceeds address space");
    end
  endgenerate

  state_t             state_reg;
  logic [ADDR_W-1:0]  base_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [CNT_W-1:0]   len_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [DATA_W-1:0]  data_reg;
  logic               en_reg;
  logic               valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [CNT_W-1:0]   len_clamped;
  logic               cap_strobe;

  assign len_clamped = CNT_W'(clamp_len(32'(length), MAX_DEPTH));

  bram_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (abort),
    .en     (en_reg),
    .strobe (cap_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      base_reg     <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      data_reg     <= '0;
      en_reg       <= 1'b0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      en_reg   <= 1'b0;
      done_reg <= 1'b0;
      // abort outranks everything, including a tx_done in the same cycle
      if (abort) begin
        state_reg <= ST_IDLE;
        valid_reg <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              base_reg     <= base_addr;
              len_reg      <= len_clamped;
              word_cnt_reg <= '0;
              if (len_clamped == '0) begin
                done_reg <= 1'b1;
              end else begin
                addr_reg  <= base_addr;
                en_reg    <= 1'b1;
                busy_reg  <= 1'b1;
                state_reg <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            state_reg <= ST_WAIT;
          end
          ST_WAIT: begin
            if (cap_strobe) begin
              data_reg  <= bram_dout;
              valid_reg <= 1'b1;
              state_reg <= ST_PRESENT;
            end
          end
          ST_PRESENT: begin
            if (tx_done) begin
              valid_reg    <= 1'b0;
              word_cnt_reg <= word_cnt_reg + CNT_W'(1);
              state_reg    <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            en_reg    <= 1'b1;
            state_reg <= ST_ISSUE;
            if (word_cnt_reg == len_reg) begin
              done_reg <= 1'b1;
              if (loop_mode) begin
                word_cnt_reg <= '0;
                addr_reg     <= base_reg;
              end else begin
                en_reg    <= 1'b0;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end else begin
              addr_reg <= addr_reg + ADDR_W'(1);
            end
          end
          default: begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bram_addr = addr_reg;
  assign bram_en   = en_reg;
  assign bram_we   = 1'b0;
  assign tx_data   = data_reg;
  assign tx_valid  = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: expected addresses/words are queued
// at start and checked as bram_en pulses and tx_valid rises appear.
module tb_bram_stream_reader;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 2;
  localparam int MAX_DEPTH = 16;
  localparam int ACK_DLY   = 5;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              loop_mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_done;
  logic              busy;
  logic              done;

  bram_stream_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .loop_mode (loop_mode),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_dout (bram_dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_done   (tx_done),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] dly [RD_LAT];

  // BRAM model: data appears RD_LAT cycles after the enable, junk otherwise
  always @(posedge clk) begin
    dly[0] <= bram_en ? mem[bram_addr] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end
  assign bram_dout = dly[RD_LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int                addr_q [$];
  logic [DATA_W-1:0] data_q [$];
  int                cyc = 0;
  int                last_en_cyc = 0;
  int                fall_cyc = -1;
  int                en_cnt = 0;
  int                valid_cnt = 0;
  int                done_cnt = 0;
  logic              prev_valid = 1'b0;
  logic [DATA_W-1:0] held_data = '0;
  logic              ack_en = 1'b1;
  int                ack_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (bram_en) begin
      en_cnt++;
      last_en_cyc = cyc;
      check_val("en_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) check_val("bram_addr", bram_addr, addr_q.pop_front());
    end
    if (tx_valid && !prev_valid) begin
      valid_cnt++;
      check_val("en_to_valid", cyc - last_en_cyc, RD_LAT + 1);
      if (fall_cyc >= 0) check_val("turnaround", cyc - fall_cyc, RD_LAT + 2);
      check_val("data_expected", data_q.size() != 0, 1);
      if (data_q.size() != 0) check_val("tx_data", tx_data, data_q.pop_front());
      held_data = tx_data;
      $display("word addr=%0d data=0x%02h cyc=%0d", bram_addr, tx_data, cyc);
    end else if (tx_valid) begin
      check_val("tx_hold", tx_data, held_data);
    end
    if (prev_valid && !tx_valid) fall_cyc = cyc;
    if (!busy) fall_cyc = -1;
    if (done) done_cnt++;
    prev_valid = tx_valid;
  end

  // UART stand-in: acknowledges each word ACK_DLY cycles after tx_valid rises
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en) begin
        if (tx_valid && ack_cnt < ACK_DLY) begin
          ack_cnt++;
          tx_done = (ack_cnt == ACK_DLY);
        end else begin
          tx_done = 1'b0;
          ack_cnt = 0;
        end
      end
    end
  end

  task automatic push_pass(input int base, input int len);
    int n;
    int a;
    n = (len > MAX_DEPTH) ? MAX_DEPTH : len;
    for (int i = 0; i < n; i++) begin
      a = (base + i) % (1 << ADDR_W);
      addr_q.push_back(a);
      data_q.push_back(mem[a]);
    end
  endtask

  task automatic pulse_start(input int base, input int len, input logic lp);
    @(negedge clk);
    base_addr = base[ADDR_W-1:0];
    length    = len[ADDR_W:0];
    loop_mode = lp;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check_val("idle_reached", busy, 0);
    @(negedge clk);
  endtask

  task automatic run_oneshot(input int base, input int len);
    int d0, e0, n;
    n  = (len > MAX_DEPTH) ? MAX_DEPTH : len;
    d0 = done_cnt;
    e0 = en_cnt;
    push_pass(base, len);
    pulse_start(base, len, 1'b0);
    wait_idle(2000);
    $display("pass base=%0d len=%0d words=%0d done=%0d", base, len, en_cnt - e0, done_cnt - d0);
    check_val("pass_done_cnt", done_cnt - d0, 1);
    check_val("pass_en_cnt", en_cnt - e0, n);
    check_val("pass_addr_left", addr_q.size(), 0);
    check_val("pass_data_left", data_q.size(), 0);
  endtask

  initial begin
    int d0, e0, v0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom_range(1, 255));
    rst_n = 1'b0; start = 1'b0; loop_mode = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_tx_valid", tx_valid, 0);
    check_val("rst_bram_en", bram_en, 0);
    check_val("rst_bram_addr", bram_addr, 0);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_done", done, 0);
    check_val("bram_we", bram_we, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_oneshot(3, 4);
    run_oneshot(14, 4);
    run_oneshot(5, 20);

    // zero length: done one cycle after start, no reads
    e0 = en_cnt; v0 = valid_cnt;
    pulse_start(7, 0, 1'b0);
    check_val("len0_done", done, 1);
    check_val("len0_busy", busy, 0);
    @(negedge clk);
    check_val("len0_done_pulse", done, 0);
    repeat (4) @(negedge clk);
    check_val("len0_en_cnt", en_cnt - e0, 0);
    check_val("len0_valid_cnt", valid_cnt - v0, 0);
    $display("pass base=7 len=0 words=%0d", en_cnt - e0);

    // loop mode, dropped after the second pass completes
    d0 = done_cnt; e0 = en_cnt;
    for (int p = 0; p < 3; p++) push_pass(0, 2);
    pulse_start(0, 2, 1'b1);
    for (int i = 0; i < 500 && (done_cnt - d0) < 2; i++) @(negedge clk);
    loop_mode = 1'b0;
    wait_idle(500);
    $display("loop base=0 len=2 words=%0d done=%0d", en_cnt - e0, done_cnt - d0);
    check_val("loop_done_cnt", done_cnt - d0, 3);
    check_val("loop_en_cnt", en_cnt - e0, 6);
    check_val("loop_addr_left", addr_q.size(), 0);

    // abort coincident with tx_done while presenting the first word
    ack_en = 1'b0;
    tx_done = 1'b0;
    d0 = done_cnt; e0 = en_cnt;
    push_pass(5, 1);
    pulse_start(5, 3, 1'b0);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    check_val("abort_valid_seen", tx_valid, 1);
    tx_done = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    abort   = 1'b0;
    check_val("abort_tx_valid", tx_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_bram_en", bram_en, 0);
    check_val("abort_done", done, 0);
    check_val("abort_tx_data", tx_data, mem[5]);
    repeat (6) @(negedge clk);
    check_val("abort_en_cnt", en_cnt - e0, 1);
    check_val("abort_done_cnt", done_cnt - d0, 0);
    $display("abort base=5 words=%0d done=%0d", en_cnt - e0, done_cnt - d0);

    // start with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1; base_addr = 4'd2; length = 5'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_val("start_abort_busy", busy, 0);
    check_val("start_abort_en_cnt", en_cnt - e0, 1);

    ack_en = 1'b1;
    run_oneshot(9, 2);

    // async reset mid-WAIT
    push_pass(2, 3);
    pulse_start(2, 3, 1'b0);
    for (int i = 0; i < 20 && !bram_en; i++) @(negedge clk);
    check_val("rstw_en_seen", bram_en, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstw_busy", busy, 0);
    check_val("rstw_bram_en", bram_en, 0);
    check_val("rstw_bram_addr", bram_addr, 0);
    check_val("rstw_tx_valid", tx_valid, 0);
    check_val("rstw_tx_data", tx_data, 0);
    check_val("rstw_done", done, 0);
    $display("reset mid-wait busy=%0d tx_valid=%0d", busy, tx_valid);
    addr_q.delete();
    data_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // stray tx_done while idle
    ack_en = 1'b0;
    v0 = valid_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
      check_val("idle_tx_valid", tx_valid, 0);
    end
    check_val("idle_valid_cnt", valid_cnt - v0, 0);
    check_val("idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
